// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and types for the instruction fetch stage:
//                default PC / memory widths, reset PC, instruction width and
//                the {pc, instr} bundle handed to decode.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam int          IMEM_AW_DEF  = 7;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INSTR_W      = 32;

  // Fetch-to-decode payload; pc is sized at the default PC width
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_out_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_next_pc
//  Description : Next-PC priority mux and sequential incrementer. Selects the
//                PC whose word is addressed this cycle: redirect target, the
//                current PC (priming after reset or holding on a stall), or
//                the sequential successor. Redirect targets are word-aligned
//                here so the PC register only ever holds aligned values.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_next_pc #(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] i_pc_q,
  input  logic            i_vld_q,
  input  logic            i_stall,
  input  logic            i_redirect_valid,
  input  logic [PC_W-1:0] i_redirect_pc,
  output logic [PC_W-1:0] o_nxt_pc
);

  localparam logic [PC_W-1:0] C_ALIGN_MASK = ~PC_W'(3);
  localparam logic [PC_W-1:0] C_INSN_BYTES = PC_W'(4);

  // Priority: redirect, then prime/hold, then sequential (wraps mod 2^PC_W)
  always_comb begin
    o_nxt_pc = i_pc_q + C_INSN_BYTES;
    if (i_redirect_valid) begin
      o_nxt_pc = i_redirect_pc & C_ALIGN_MASK;
    end else if (!i_vld_q || i_stall) begin
      o_nxt_pc = i_pc_q;
    end
  end

endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : PC generator and fetch stage feeding a 1-cycle-latency
//                synchronous instruction memory. The PC register tracks the
//                address whose word is currently on imem_data, so the
//                returned word is passed straight through alongside it.
//                Stalls re-read the same word to keep the data stable.
//  Options     : FETCH_MISALIGN_CHK_EN - when defined, a redirect to a
//                non-word-aligned target raises a sticky fetch_fault that
//                suppresses out_valid until an aligned redirect or reset.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              IMEM_AW  = IMEM_AW_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               fetch_fault
);

  logic [PC_W-1:0] r_pc;
  logic            r_vld;
  logic            w_fault;
  logic            w_out_valid;
  logic            w_stall;
  logic [PC_W-1:0] w_nxt_pc;
  fetch_out_t      w_out;

  assign w_out_valid = r_vld & ~w_fault;
  assign w_stall     = w_out_valid & ~out_ready;

  fetch_next_pc #(
    .PC_W (PC_W)
  ) u_next_pc (
    .i_pc_q           (r_pc),
    .i_vld_q          (r_vld),
    .i_stall          (w_stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_nxt_pc         (w_nxt_pc)
  );

  // The memory sees the next PC now and returns its word as r_pc updates
  assign imem_addr = w_nxt_pc[IMEM_AW+1:2];

  // PC of the word arriving on imem_data; valid from the first edge after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_PC;
      r_vld <= 1'b0;
    end else begin
      r_pc  <= w_nxt_pc;
      r_vld <= 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_fault;

  // Sticky misalignment flag, re-evaluated on every redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_fault <= |redirect_pc[1:0];
    end
  end

  assign w_fault = r_fault;
`else
  assign w_fault = 1'b0;
`endif

  // Assemble the decode payload; the instruction is a pure pass-through
  always_comb begin
    w_out       = '0;
    w_out.pc    = PC_W_DEF'(r_pc);
    w_out.instr = imem_data;
  end

  assign out_valid   = w_out_valid;
  assign out_pc      = w_out.pc[PC_W-1:0];
  assign out_instr   = w_out.instr;
  assign fetch_fault = w_fault;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Self-checking bench for instruction_fetch: directed vector
//                table, misalignment and reset-mid-stall sequences, and a
//                randomized run against a behavioural fetch model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  instruction_fetch #(
    .PC_W     (32),
    .IMEM_AW  (7),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, 1-cycle read latency, mem[k] = k + 0x100
  logic [31:0] mem [128];
  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 32'h100 + k;
  end
  always @(posedge clk) imem_data <= mem[imem_addr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what decode should see, in terms of byte PCs
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_fault;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h100 + ((pc >> 2) % 128);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_fault = 1'b0;
  endtask

  task automatic model_check();
    bit shown;
    shown = m_valid && !m_fault;
    check("model_valid", {31'b0, out_valid}, {31'b0, shown});
    check("model_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    if (shown) begin
      check("model_pc", out_pc, m_pc);
      check("model_instr", out_instr, word_at(m_pc));
    end
  endtask

  task automatic model_update(input bit rv, input logic [31:0] rpc, input bit rdy);
    bit shown;
    shown = m_valid && !m_fault;
    if (rv) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_fault = MIS && (rpc[1:0] != 2'b00);
      m_valid = 1'b1;
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!(shown && !rdy)) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: drive, check at negedge, advance at posedge
  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update(rv, rpc, rdy);
    #1;
  endtask

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] einstr;
  } vec_t;

  vec_t vec [21];

  initial begin
    //           rv  rpc           rdy ev  epc           einstr
    vec[0]  = '{0, 32'h0,        1,  0,  32'h0,        32'h0};
    vec[1]  = '{0, 32'h0,        1,  1,  32'h0,        32'h100};
    vec[2]  = '{0, 32'h0,        1,  1,  32'h4,        32'h101};
    vec[3]  = '{0, 32'h0,        0,  1,  32'h8,        32'h102};
    vec[4]  = '{0, 32'h0,        0,  1,  32'h8,        32'h102};
    vec[5]  = '{0, 32'h0,        0,  1,  32'h8,        32'h102};
    vec[6]  = '{0, 32'h0,        1,  1,  32'h8,        32'h102};
    vec[7]  = '{0, 32'h0,        1,  1,  32'hC,        32'h103};
    vec[8]  = '{1, 32'h40,       1,  1,  32'h10,       32'h104};
    vec[9]  = '{0, 32'h0,        1,  1,  32'h40,       32'h110};
    vec[10] = '{0, 32'h0,        1,  1,  32'h44,       32'h111};
    vec[11] = '{1, 32'h14,       1,  1,  32'h48,       32'h112};
    vec[12] = '{0, 32'h0,        0,  1,  32'h14,       32'h105};
    vec[13] = '{1, 32'h20,       0,  1,  32'h14,       32'h105};
    vec[14] = '{1, 32'h1FC,      1,  1,  32'h20,       32'h108};
    vec[15] = '{0, 32'h0,        1,  1,  32'h1FC,      32'h17F};
    vec[16] = '{0, 32'h0,        1,  1,  32'h200,      32'h100};
    vec[17] = '{1, 32'hFFFFFFFC, 1,  1,  32'h204,      32'h101};
    vec[18] = '{0, 32'h0,        1,  1,  32'hFFFFFFFC, 32'h17F};
    vec[19] = '{0, 32'h0,        1,  1,  32'h0,        32'h100};
    vec[20] = '{0, 32'h0,        1,  1,  32'h4,        32'h101};

    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, out_valid}, 32'h0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_fault", {31'b0, fetch_fault}, 32'h0);
    check("reset_imem_addr", {25'b0, imem_addr}, 32'h0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 21; i++) begin
      redirect_valid = vec[i].rv;
      redirect_pc    = vec[i].rpc;
      out_ready      = vec[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vec[i].ev});
      if (vec[i].ev) begin
        check($sformatf("vec%0d_pc", i), out_pc, vec[i].epc);
        check($sformatf("vec%0d_instr", i), out_instr, vec[i].einstr);
      end
      model_check();
      @(posedge clk);
      model_update(vec[i].rv, vec[i].rpc, vec[i].rdy);
      #1;
    end

    // Misaligned redirect, then aligned redirect clears any fault
    step(1'b1, 32'h42, 1'b1);
    if (MIS) begin
      check("mis_fault_set", {31'b0, fetch_fault}, 32'h1);
      check("mis_valid_off", {31'b0, out_valid}, 32'h0);
    end else begin
      check("mis_fault_tied", {31'b0, fetch_fault}, 32'h0);
      check("mis_pc_aligned", out_pc, 32'h40);
      check("mis_instr", out_instr, 32'h110);
    end
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h44, 1'b1);
    check("align_fault_clr", {31'b0, fetch_fault}, 32'h0);
    check("align_valid", {31'b0, out_valid}, 32'h1);
    check("align_pc", out_pc, 32'h44);
    check("align_instr", out_instr, 32'h111);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) != 0);
    end
    step(1'b1, 32'h30, 1'b1);

    // Reset asserted in the middle of a stall
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("prestall_valid", {31'b0, out_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_pc", out_pc, 32'h0);
    check("midrst_fault", {31'b0, fetch_fault}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, 32'h0, 1'b1);
    check("restart_pc0", out_pc, 32'h0);
    check("restart_instr0", out_instr, 32'h100);
    step(1'b0, 32'h0, 1'b1);
    check("restart_pc4", out_pc, 32'h4);
    step(1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
